// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage feeding the processor decode/execute logic. Holds the PC, issues
//   word reads to the instruction memory port, buffers returned words in a small
//   FIFO and presents them over a valid/ready handshake. A redirect (taken
//   branch/jump) flushes the FIFO and any in-flight fetch and restarts at the
//   word-aligned target.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     imem_req, imem_addr      read strobe / word address to instruction memory
//     imem_rdata               read data, valid one cycle after imem_req
//     redirect_valid/_pc       branch/jump redirect and its target
//     out_valid/ready          handshake towards the processor
//     out_instr, out_pc        head-of-FIFO instruction and its address
//     perf_fetch_cnt           delivered instructions (saturating)
//     perf_stall_cnt           cycles with out_valid && !out_ready (saturating)
//
//   Optional feature: define IFU_PERF_CNT_EN to build the performance counters;
//   otherwise both perf ports are tied to zero.

module instr_fetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h00000000,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = PTR_W + 2;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;

    logic [31:0]       instr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_q    [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              issue;
    logic              push;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;

    // Occupancy credits a same-cycle pop so that a steady stream with
    // out_ready=1 keeps one fetch issued per cycle; the FIFO still cannot
    // overflow because every slot counted here is either filled or in flight.
    always_comb begin
        pop       = (count != '0) && out_ready && !redirect_valid;
        push      = inflight && !redirect_valid;
        occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        issue     = !rst && !redirect_valid && (occupancy < OCC_W'(FIFO_DEPTH));
    end

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_instr = instr_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];

    // PC and the single outstanding-fetch tracker. A redirect kills the
    // outstanding fetch so its returning data is never pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~ADDR_W'(3);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + ADDR_W'(4);
                inflight_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc_q[wr_ptr]    <= inflight_pc;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a directed vector table (stream, backpressure,
// flush, misaligned redirect), counter/reset sequences, and a randomized run.
// A second instance starting at 32'hFFFFFFFC exercises PC wrap.

module tb_instr_fetch_unit;

    localparam logic [31:0] MAGIC   = 32'hA5A50000;
    localparam logic [31:0] WRAP_PC = 32'hFFFFFFFC;
`ifdef IFU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_fetch;
    logic [31:0] w_stall;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    instr_fetch_unit #(.RESET_PC(WRAP_PC)) dut_w (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (w_valid),
        .out_ready      (1'b1),
        .out_instr      (w_instr),
        .out_pc         (w_pc),
        .perf_fetch_cnt (w_fetch),
        .perf_stall_cnt (w_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at A is A ^ MAGIC, returned one cycle later.
    always @(posedge clk) begin
        imem_rdata <= imem_addr ^ MAGIC;
        w_rdata    <= w_addr ^ MAGIC;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the architectural instruction stream plus latency rules.
    logic [31:0] next_pc;     // address of the next instruction to be delivered
    int          idx;         // cycles since restart (reset release or redirect)
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;
    logic [31:0] w_next;
    int          w_idx;

    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        bit          ereq;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        chk("rst_req",     32'(imem_req), 32'd0);
        chk("rst_addr",    imem_addr, 32'h0);
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_instr",   out_instr, 32'h0);
        chk("rst_pc",      out_pc, 32'h0);
        chk("rst_fetch",   perf_fetch_cnt, 32'h0);
        chk("rst_stall",   perf_stall_cnt, 32'h0);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_addr",  w_addr, WRAP_PC);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        next_pc   = 32'h0;
        idx       = 0;
        exp_fetch = '0;
        exp_stall = '0;
        w_next    = WRAP_PC;
        w_idx     = 0;
    endtask

    task automatic apply(input bit rdy, input bit rv, input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic finish_cycle();
        chk("out_valid", 32'(out_valid), 32'(idx >= 2));
        if (out_valid) begin
            chk("out_pc",    out_pc, next_pc);
            chk("out_instr", out_instr, next_pc ^ MAGIC);
        end
        if (redirect_valid) begin
            chk("req_in_redirect", 32'(imem_req), 32'd0);
        end else if (idx == 0) begin
            chk("first_req",  32'(imem_req), 32'd1);
            chk("first_addr", imem_addr, next_pc);
        end
        chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        chk("perf_fetch", perf_fetch_cnt, PERF ? exp_fetch : 32'h0);
        chk("perf_stall", perf_stall_cnt, PERF ? exp_stall : 32'h0);
        chk("w_valid", 32'(w_valid), 32'(w_idx >= 2));
        if (w_valid) begin
            chk("w_pc",    w_pc, w_next);
            chk("w_instr", w_instr, w_next ^ MAGIC);
        end

        if (out_valid && out_ready && !redirect_valid) begin
            next_pc = next_pc + 32'd4;
            if (exp_fetch != '1) exp_fetch = exp_fetch + 32'd1;
        end
        if (out_valid && !out_ready && exp_stall != '1) exp_stall = exp_stall + 32'd1;
        if (redirect_valid) begin
            next_pc = redirect_pc & 32'hFFFFFFFC;
            idx     = 0;
        end else if (idx < 1000) begin
            idx++;
        end
        if (w_valid) w_next = w_next + 32'd4;
        if (w_idx < 1000) w_idx++;
        @(negedge clk);
    endtask

    initial begin
        // stream, backpressure, flush to 0x100, misaligned redirect to 0x103
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h100, 1'b1, 32'hC,   1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1};
        tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1};
        tbl[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 32'h103, 1'b1, 32'h104, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1};
        tbl[17] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1};
        tbl[18] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].ereq));
            if (tbl[i].ev) chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
            finish_cycle();
        end

        // 10 accepted then 3 stalled cycles
        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 1'b0, 32'h0);
            finish_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 32'h0);
            finish_cycle();
        end
        apply(1'b0, 1'b0, 32'h0);
        chk("cnt_fetch10", perf_fetch_cnt, PERF ? 32'd10 : 32'd0);
        chk("cnt_stall3",  perf_stall_cnt, PERF ? 32'd3 : 32'd0);
        finish_cycle();

        // reset asserted between clock edges mid-stream
        #2;
        do_reset();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h3FF)
                                              : (32'hFFFFFFE0 | ($urandom & 32'h1F));
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, tgt);
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
